// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencer and its shift generator.
package cordic_pkg;

  localparam int SHIFT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Hyperbolic micro-rotations at these indices are issued twice for convergence.
  localparam int HYP_REPEAT_0 = 4;
  localparam int HYP_REPEAT_1 = 13;
  localparam int HYP_REPEAT_2 = 40;

  localparam logic SYS_CIRC = 1'b1;
  localparam logic SYS_HYP  = 1'b0;
  localparam logic MODE_ROT = 1'b1;
  localparam logic MODE_VEC = 1'b0;

  function automatic logic is_hyp_repeat(input logic [SHIFT_W-1:0] s);
    int si;
    si = int'(s);
    return (si == HYP_REPEAT_0) || (si == HYP_REPEAT_1) || (si == HYP_REPEAT_2);
  endfunction

endpackage

// File: rtl/cordic_shift_gen.sv
// Registered shift-index generator: circular counts 0,1,2,..; hyperbolic starts
// at 1 and repeats the convergence indices once. Saturates at the maximum index.
module cordic_shift_gen
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               advance,
  input  logic               system,
  output logic [SHIFT_W-1:0] shift
);

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               rep_q, rep_d;

  always_comb begin
    shift_d = shift_q;
    rep_d   = rep_q;
    if (start) begin
      shift_d = (system == SYS_CIRC) ? '0 : SHIFT_W'(1);
      rep_d   = 1'b0;
    end else if (advance) begin
      // rep_q marks that the current index has already been issued once
      if ((system == SYS_HYP) && is_hyp_repeat(shift_q) && !rep_q) begin
        rep_d = 1'b1;
      end else begin
        rep_d = 1'b0;
        if (shift_q != '1) shift_d = shift_q + SHIFT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rep_q   <= rep_d;
    end
  end

  assign shift = shift_q;

endmodule

// File: rtl/cordic_controller.sv
// Sequencer for the iterative CORDIC core: accepts one operation, loads the core,
// issues the micro-rotation enables, and returns the captured result.
module cordic_controller
  import cordic_pkg::*;
#(
  parameter int p_WIDTH      = 32,
  parameter int p_ITERATIONS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [p_WIDTH-1:0] in_x,
  input  logic [p_WIDTH-1:0] in_y,
  input  logic [p_WIDTH-1:0] in_z,
  input  logic               in_system,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [p_WIDTH-1:0] out_x,
  output logic [p_WIDTH-1:0] out_y,
  output logic [p_WIDTH-1:0] out_z,
  output logic               out_overflow,
  output logic [4:0]         out_iters,
  output logic               core_load,
  output logic [p_WIDTH-1:0] core_x_in,
  output logic [p_WIDTH-1:0] core_y_in,
  output logic [p_WIDTH-1:0] core_z_in,
  output logic               core_system,
  output logic               core_mode,
  output logic               core_en,
  output logic [4:0]         core_shift,
  input  logic [p_WIDTH-1:0] core_x_out,
  input  logic [p_WIDTH-1:0] core_y_out,
  input  logic [p_WIDTH-1:0] core_z_out,
  input  logic               core_overflow,
  output logic [2:0]         dbg_state_o
);

  localparam logic [SHIFT_W-1:0] ITER_LAST = SHIFT_W'(p_ITERATIONS - 1);
  localparam logic [SHIFT_W-1:0] ITER_FULL = SHIFT_W'(p_ITERATIONS);

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] count_q, count_d;
  logic [p_WIDTH-1:0] x_q, y_q, z_q;
  logic               sys_q, mode_q;
  logic [p_WIDTH-1:0] res_x_q, res_y_q, res_z_q;
  logic               res_ovf_q;
  logic [SHIFT_W-1:0] res_iters_q;
  logic               accept, cap, cap_ovf;
  logic [SHIFT_W-1:0] cap_iters;

  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cap       = 1'b0;
    cap_ovf   = 1'b0;
    cap_iters = '0;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        // Overflow reports the previous update, so abort before issuing another enable.
        if (core_overflow) begin
          cap       = 1'b1;
          cap_ovf   = 1'b1;
          cap_iters = count_q;
          state_d   = ST_DONE;
        end else begin
          if (count_q != '1) count_d = count_q + SHIFT_W'(1);
          if (count_q == ITER_LAST) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cap       = 1'b1;
        cap_ovf   = core_overflow;
        cap_iters = core_overflow ? ITER_LAST : ITER_FULL;
        state_d   = ST_DONE;
      end
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      sys_q       <= 1'b0;
      mode_q      <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_z_q     <= '0;
      res_ovf_q   <= 1'b0;
      res_iters_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        x_q    <= in_x;
        y_q    <= in_y;
        z_q    <= in_z;
        sys_q  <= in_system;
        mode_q <= in_mode;
      end
      if (cap) begin
        res_x_q     <= core_x_out;
        res_y_q     <= core_y_out;
        res_z_q     <= core_z_out;
        res_ovf_q   <= cap_ovf;
        res_iters_q <= cap_iters;
      end
    end
  end

  cordic_shift_gen u_shift_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (state_q == ST_LOAD),
    .advance (core_en),
    .system  (sys_q),
    .shift   (core_shift)
  );

  assign in_ready     = (state_q == ST_IDLE) && !rst;
  assign out_valid    = (state_q == ST_DONE);
  assign out_x        = res_x_q;
  assign out_y        = res_y_q;
  assign out_z        = res_z_q;
  assign out_overflow = res_ovf_q;
  assign out_iters    = res_iters_q;
  assign core_load    = (state_q == ST_LOAD);
  assign core_x_in    = x_q;
  assign core_y_in    = y_q;
  assign core_z_in    = z_q;
  assign core_system  = sys_q;
  assign core_mode    = mode_q;
  assign core_en      = (state_q == ST_ITER) && !core_overflow;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cordic_controller.sv
// Bench for cordic_controller: model CORDIC core, operation-level reference model,
// one compare process on the result/enable streams, and directed scenarios.
module tb_cordic_controller;
  import cordic_pkg::*;

  localparam int  W  = 32;
  localparam int  P  = 15;
  localparam real PI = 3.14159265358979;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic       ovf;
    logic [4:0] iters;
    int         nen;
    int         lat;
    int         hs;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid = 1'b0, in_ready, in_system = 1'b0, in_mode = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic         out_valid, out_ready = 1'b1, out_overflow;
  logic [W-1:0] out_x, out_y, out_z;
  logic [4:0]   out_iters, core_shift;
  logic         core_load, core_system, core_mode, core_en;
  logic [W-1:0] core_x_in, core_y_in, core_z_in, core_x_out, core_y_out, core_z_out;
  logic         core_overflow;
  logic [2:0]   dbg_state;

  cordic_controller #(.p_WIDTH(W), .p_ITERATIONS(P)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_system(in_system), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_overflow(out_overflow), .out_iters(out_iters),
    .core_load(core_load), .core_x_in(core_x_in), .core_y_in(core_y_in), .core_z_in(core_z_in),
    .core_system(core_system), .core_mode(core_mode), .core_en(core_en), .core_shift(core_shift),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_z_out(core_z_out),
    .core_overflow(core_overflow), .dbg_state_o(dbg_state)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- CORDIC arithmetic (angle scale: 2^31 = 180 deg) ----------------
  int atan_tab[32];
  int atanh_tab[32];
  initial begin
    real t;
    t = 1.0;
    for (int i = 0; i < 32; i++) begin
      atan_tab[i]  = $rtoi($atan(t) / PI * 2.0**31);
      atanh_tab[i] = (i == 0) ? 0 : $rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) / PI * 2.0**31);
      t = t / 2.0;
    end
  end

  function automatic vec_t rot_step(input vec_t v, input int s, input logic sys, input logic mode);
    logic signed [W-1:0] x, y, z, xs, ys, a;
    logic dp;
    vec_t r;
    x = v.x; y = v.y; z = v.z;
    xs = x >>> s;
    ys = y >>> s;
    a  = sys ? atan_tab[s] : atanh_tab[s];
    dp = mode ? (z >= 0) : (y < 0);
    if (sys) begin
      r.x = dp ? x - ys : x + ys;
    end else begin
      r.x = dp ? x + ys : x - ys;
    end
    r.y = dp ? y + xs : y - xs;
    r.z = dp ? z - a : z + a;
    return r;
  endfunction

  // Shift index for the idx-th micro-rotation, straight from the schedule rules.
  function automatic int sched(input logic sys, input int idx);
    int k;
    if (sys) return (idx > 31) ? 31 : idx;
    k = 0;
    for (int s = 1; s < 64; s++) begin
      if (k == idx) return (s > 31) ? 31 : s;
      k++;
      if (s == 4 || s == 13 || s == 40) begin
        if (k == idx) return (s > 31) ? 31 : s;
        k++;
      end
    end
    return 31;
  endfunction

  // ---------------- model core ----------------
  int   ovf_after = 1000;
  vec_t core_v = '0;
  int   en_cnt = 0;
  logic core_ovf = 1'b0;
  always @(posedge clk) begin
    if (core_load) begin
      core_v   <= {core_x_in, core_y_in, core_z_in};
      en_cnt   <= 0;
      core_ovf <= (ovf_after == 0);
    end else if (core_en) begin
      core_v   <= rot_step(core_v, int'(core_shift), core_system, core_mode);
      en_cnt   <= en_cnt + 1;
      core_ovf <= (en_cnt + 1 >= ovf_after);
    end
  end
  assign core_x_out    = core_v.x;
  assign core_y_out    = core_v.y;
  assign core_z_out    = core_v.z;
  assign core_overflow = core_ovf;

  // ---------------- reference model of one operation ----------------
  function automatic exp_t ref_op(input vec_t v0, input logic sys, input logic mode, input int oa);
    exp_t e;
    int   k;
    vec_t v;
    k = (oa < P) ? oa : P;
    v = v0;
    for (int i = 0; i < k; i++) v = rot_step(v, sched(sys, i), sys, mode);
    e.v = v;
    if (oa < P) begin
      e.ovf = 1'b1; e.iters = 5'(oa);
    end else if (oa == P) begin
      e.ovf = 1'b1; e.iters = 5'(P - 1);
    end else begin
      e.ovf = 1'b0; e.iters = 5'(P);
    end
    e.nen = k;
    e.lat = 3 + k;
    e.hs  = 0;
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t       exp_q[$];
  exp_t       m_e;
  logic       cur_sys = 1'b1;
  int         en_seen = 0;
  int         n_res = 0;
  int         shift_log[$];
  logic       prev_hold = 1'b0;
  vec_t       held_v;
  logic       held_ovf;
  logic [4:0] held_it;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (prev_hold) begin
          chk("hold_x", out_x, held_v.x);
          chk("hold_y", out_y, held_v.y);
          chk("hold_z", out_z, held_v.z);
          chk("hold_ovf", out_overflow, held_ovf);
          chk("hold_iters", out_iters, held_it);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          n_res++;
          chk("res_x", out_x, m_e.v.x);
          chk("res_y", out_y, m_e.v.y);
          chk("res_z", out_z, m_e.v.z);
          chk("res_ovf", out_overflow, m_e.ovf);
          chk("res_iters", out_iters, m_e.iters);
          chk("en_count", en_seen, m_e.nen);
          chk("latency", cyc - m_e.hs, m_e.lat);
        end
        held_v   = {out_x, out_y, out_z};
        held_ovf = out_overflow;
        held_it  = out_iters;
        prev_hold = !out_ready;
      end else begin
        prev_hold = 1'b0;
      end
      if (core_en) begin
        chk("shift", core_shift, sched(cur_sys, en_seen));
        shift_log.push_back(int'(core_shift));
        en_seen++;
      end
      if (in_valid && in_ready) begin
        m_e    = ref_op({in_x, in_y, in_z}, in_system, in_mode, ovf_after);
        m_e.hs = cyc;
        exp_q.push_back(m_e);
        en_seen = 0;
        cur_sys = in_system;
        shift_log.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  int hs_c = 0, res_cyc = 0, n_sent = 0;

  task automatic send(input logic [W-1:0] x, y, z, input logic sys, mode);
    bit ok;
    ok = 0;
    in_x = x; in_y = y; in_z = z; in_system = sys; in_mode = mode;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    hs_c = cyc;
    if (!ok) chk("send_timeout", 0, 1);
    else n_sent++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result();
    bit got;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    res_cyc = cyc;
    if (!got) chk("result_timeout", 0, 1);
    #1;
  endtask

  function automatic longint absd(input logic [W-1:0] a, input real r);
    longint d;
    d = longint'($signed(a)) - longint'($rtoi(r * 2.0**31));
    return (d < 0) ? -d : d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int hyp_exp[15];
  int n_aborted = 0;
  logic [W-1:0] rx, ry, rz;
  logic rs, rm;

  initial begin
    hyp_exp = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_iters", out_iters, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // circular rotation by 45 deg of (K, 0)
    send(W'($rtoi(0.6072529 * 2.0**31)), '0, 32'h2000_0000, SYS_CIRC, MODE_ROT);
    wait_result();
    chk("circ_x_near", absd(out_x, 0.70710678) < 214748, 1);
    chk("circ_y_near", absd(out_y, 0.70710678) < 214748, 1);
    chk("circ_z_near0", absd(out_z, 0.0) < 214748, 1);
    chk("circ_ovf", out_overflow, 0);
    chk("circ_iters", out_iters, 15);
    chk("circ_latency18", res_cyc - hs_c, 18);
    chk("circ_nshift", shift_log.size(), 15);
    for (int i = 0; i < 15; i++) chk("circ_shift_lit", shift_log[i], i);
    @(posedge clk);
    #1;

    // hyperbolic rotation: shift schedule pinned literally
    send(32'h6666_6666, 32'h0000_0000, W'($rtoi(0.3 / PI * 2.0**31)), SYS_HYP, MODE_ROT);
    wait_result();
    chk("hyp_nshift", shift_log.size(), 15);
    for (int i = 0; i < 15; i++) chk("hyp_shift_lit", shift_log[i], hyp_exp[i]);
    chk("hyp_iters", out_iters, 15);
    @(posedge clk);
    #1;

    // core overflow after the 6th enable
    ovf_after = 6;
    send(32'h2000_0000, 32'h1000_0000, 32'h1000_0000, SYS_CIRC, MODE_VEC);
    wait_result();
    chk("ovf6_en_pulses", shift_log.size(), 6);
    chk("ovf6_flag", out_overflow, 1);
    chk("ovf6_iters", out_iters, 6);
    chk("ovf6_latency", res_cyc - hs_c, 9);
    @(posedge clk);

    // overflow straight from the load
    #1 ovf_after = 0;
    send(32'h2000_0000, 32'h1000_0000, 32'h0, SYS_CIRC, MODE_ROT);
    wait_result();
    chk("ovf0_en_pulses", shift_log.size(), 0);
    chk("ovf0_iters", out_iters, 0);
    chk("ovf0_flag", out_overflow, 1);
    @(posedge clk);

    // overflow reported by the final update
    #1 ovf_after = P;
    send(32'h2000_0000, 32'h0, 32'h0800_0000, SYS_HYP, MODE_ROT);
    wait_result();
    chk("ovf15_iters", out_iters, 14);
    chk("ovf15_flag", out_overflow, 1);
    @(posedge clk);
    #1 ovf_after = 1000;

    // result stalled 20 cycles, then released
    out_ready = 1'b0;
    send(32'h1800_0000, 32'hF800_0000, 32'h0C00_0000, SYS_CIRC, MODE_ROT);
    wait_result();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_valid_held", out_valid, 1);
    out_ready = 1'b1;
    send(32'h1000_0000, 32'h0400_0000, 32'hF000_0000, SYS_HYP, MODE_VEC);
    wait_result();
    chk("post_stall_latency18", res_cyc - hs_c, 18);
    @(posedge clk);
    #1;

    // reset during the 8th ITER cycle
    send(32'h1400_0000, 32'h0, 32'h1000_0000, SYS_CIRC, MODE_ROT);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_enables", shift_log.size(), 7);
    rst = 1'b1;
    n_aborted++;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_core_en", core_en, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(32'h1400_0000, 32'h0, 32'h1000_0000, SYS_CIRC, MODE_ROT);
    wait_result();
    chk("post_rst_iters", out_iters, 15);
    chk("post_rst_ovf", out_overflow, 0);
    @(posedge clk);
    #1;

    // 50 back-to-back requests
    for (int n = 0; n < 50; n++) begin
      rs = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      rx = W'($urandom_range(32'h1000_0000, 32'h2000_0000));
      ry = W'(int'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000);
      rz = rs ? W'(int'($urandom_range(0, 32'h8000_0000)) - 32'h4000_0000)
              : W'(int'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000);
      send(rx, ry, rz, rs, rm);
    end
    wait_result();
    repeat (3) @(posedge clk);
    #1;
    chk("results_count", n_res, n_sent - n_aborted);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
